// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester (owner) encoding and the memop size/sign codes produced by the
// core's control generator.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [2:0] MEMOP_BYTE   = 3'b000;
  localparam logic [2:0] MEMOP_HALF   = 3'b001;
  localparam logic [2:0] MEMOP_WORD   = 3'b010;
  localparam logic [2:0] MEMOP_BYTE_U = 3'b100;
  localparam logic [2:0] MEMOP_HALF_U = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: one request channel (valid/ready with
// address, write enable, write data and memop) and one response channel
// (valid pulse with read data, no backpressure).
//   master : driven by the arbiter
//   slave  : driven by the memory model / bus bridge
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_memop;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_memop,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_memop,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter, purely combinational.
//   req[0] = IFU request, req[1] = LSU request
//   last_grant = owner granted most recently (OWN_IFU / OWN_LSU)
//   grant = one-hot winner, all-zero when nobody requests
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  // On a tie the requester that did not win last time gets the port.
  assign grant[0] = req[0] & (~req[1] | (last_grant == OWN_LSU));
  assign grant[1] = req[1] & (~req[0] | (last_grant == OWN_IFU));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and load/store (LSU).
// One transaction is in flight at a time: IDLE grants a requester, REQ
// presents the registered request until memory accepts it, WAIT waits for
// the response (or a timeout) and routes it back to the owner.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ifu_*               fetch request (valid/ready/addr) and response
//   lsu_*               load/store request (valid/ready/addr/wen/wdata/memop)
//                       and response
//   mem                 memory-side bus (master modport)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic              ifu_rsp_err,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [2:0]        lsu_memop,
  output logic              lsu_rsp_valid,
  output logic              lsu_rsp_err,
  output logic [DATA_W-1:0] lsu_rdata,
  mem_port_arbiter_if.master mem
);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

  state_t            state_reg;
  logic              owner_reg;
  logic              last_grant_reg;
  logic [15:0]       wait_cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_wen_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [2:0]        mem_memop_reg;
  logic              ifu_rsp_valid_reg, ifu_rsp_err_reg;
  logic              lsu_rsp_valid_reg, lsu_rsp_err_reg;
  logic [DATA_W-1:0] ifu_rdata_reg, lsu_rdata_reg;
  logic [1:0]        grant;
  logic              idle;
  logic              timeout_hit;
  logic              finish;

  rr_arbiter_2 u_arb (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign idle          = (state_reg == IDLE);
  assign ifu_req_ready = idle & grant[0];
  assign lsu_req_ready = idle & grant[1];

  // Counter starts at 0 on the first WAIT cycle, so the TIMEOUT-th WAIT
  // cycle is the last one; a response in that same cycle still wins.
  assign timeout_hit = (wait_cnt_reg + 16'd1) == TIMEOUT_LIM;
  assign finish      = (state_reg == WAIT) & (mem.mem_rsp_valid | timeout_hit);

  assign mem.mem_req_valid = (state_reg == REQ);
  assign mem.mem_addr      = mem_addr_reg;
  assign mem.mem_wen       = mem_wen_reg;
  assign mem.mem_wdata     = mem_wdata_reg;
  assign mem.mem_memop     = mem_memop_reg;

  assign ifu_rsp_valid = ifu_rsp_valid_reg;
  assign ifu_rsp_err   = ifu_rsp_err_reg;
  assign ifu_rdata     = ifu_rdata_reg;
  assign lsu_rsp_valid = lsu_rsp_valid_reg;
  assign lsu_rsp_err   = lsu_rsp_err_reg;
  assign lsu_rdata     = lsu_rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      owner_reg         <= OWN_IFU;
      last_grant_reg    <= OWN_LSU;
      wait_cnt_reg      <= '0;
      mem_addr_reg      <= '0;
      mem_wen_reg       <= 1'b0;
      mem_wdata_reg     <= '0;
      mem_memop_reg     <= '0;
      ifu_rsp_valid_reg <= 1'b0;
      ifu_rsp_err_reg   <= 1'b0;
      ifu_rdata_reg     <= '0;
      lsu_rsp_valid_reg <= 1'b0;
      lsu_rsp_err_reg   <= 1'b0;
      lsu_rdata_reg     <= '0;
    end else begin
      // Response flags are single-cycle pulses.
      ifu_rsp_valid_reg <= 1'b0;
      ifu_rsp_err_reg   <= 1'b0;
      lsu_rsp_valid_reg <= 1'b0;
      lsu_rsp_err_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (grant[0]) begin
            state_reg      <= REQ;
            owner_reg      <= OWN_IFU;
            last_grant_reg <= OWN_IFU;
            mem_addr_reg   <= ifu_addr;
            mem_wen_reg    <= 1'b0;
            mem_wdata_reg  <= '0;
            mem_memop_reg  <= MEMOP_WORD;
          end else if (grant[1]) begin
            state_reg      <= REQ;
            owner_reg      <= OWN_LSU;
            last_grant_reg <= OWN_LSU;
            mem_addr_reg   <= lsu_addr;
            mem_wen_reg    <= lsu_wen;
            mem_wdata_reg  <= lsu_wdata;
            mem_memop_reg  <= lsu_memop;
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            state_reg    <= WAIT;
            wait_cnt_reg <= '0;
          end
        end
        WAIT: begin
          if (finish) begin
            state_reg <= IDLE;
            if (owner_reg == OWN_IFU) begin
              ifu_rsp_valid_reg <= 1'b1;
              ifu_rsp_err_reg   <= ~mem.mem_rsp_valid;
              ifu_rdata_reg     <= mem.mem_rsp_valid ? mem.mem_rdata : '0;
            end else begin
              lsu_rsp_valid_reg <= 1'b1;
              lsu_rsp_err_reg   <= ~mem.mem_rsp_valid;
              lsu_rdata_reg     <= mem.mem_rsp_valid ? mem.mem_rdata : '0;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 4).
module tb_mem_port_arbiter;
  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [2:0]  lsu_memop;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_memop(lsu_memop),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err), .lsu_rdata(lsu_rdata),
    .mem(mem_bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_memop = 0;
    mem_bus.mem_req_ready = 0; mem_bus.mem_rsp_valid = 0; mem_bus.mem_rdata = 0;
    tick(); tick();
    n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_bus.mem_req_valid); end
    n_checks++; if (mem_bus.mem_memop !== 3'b000) begin n_fail++; $display("FAIL reset_mem_memop: got %b want 000", mem_bus.mem_memop); end
    n_checks++; if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err} !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_flags: got %b want 0000", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}); end
    n_checks++; if ({ifu_rdata, lsu_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {ifu_rdata, lsu_rdata}); end
    rst = 1'b0;
    tick();
    $display("txn reset: released");
  endtask

  task automatic test_lone_fetch();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_bus.mem_req_ready = 1;
    #1;
    n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin n_fail++; $display("FAIL t1_ready_c0: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
    tick(); ifu_req_valid = 0;
    n_checks++; if (mem_bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL t1_mem_req_valid_c1: got %b want 1", mem_bus.mem_req_valid); end
    n_checks++; if ({mem_bus.mem_memop, mem_bus.mem_wen} !== 4'b0100) begin n_fail++; $display("FAIL t1_memop_wen: got %b want 0100", {mem_bus.mem_memop, mem_bus.mem_wen}); end
    n_checks++; if (mem_bus.mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL t1_mem_addr: got %h want 80000000", mem_bus.mem_addr); end
    tick(); mem_bus.mem_req_ready = 0; mem_bus.mem_rsp_valid = 1; mem_bus.mem_rdata = 32'h0000_0413;
    n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL t1_mem_req_valid_c2: got %b want 0", mem_bus.mem_req_valid); end
    tick(); mem_bus.mem_rsp_valid = 0;
    n_checks++; if ({ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL t1_rsp_c3: got %b want 100", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid}); end
    n_checks++; if (ifu_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL t1_ifu_rdata: got %h want 00000413", ifu_rdata); end
    tick();
    n_checks++; if (ifu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_width: got %b want 0", ifu_rsp_valid); end
    $display("txn lone fetch: addr=80000000 rdata=%h", ifu_rdata);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_grant;
    test_reset();
    ifu_addr = 32'h0000_0100; lsu_addr = 32'h0000_0200; lsu_wen = 0; lsu_memop = 3'b100;
    ifu_req_valid = 1; lsu_req_valid = 1; mem_bus.mem_req_ready = 1;
    for (int r = 0; r < 3; r++) begin
      exp_grant = (r == 1) ? 2'b01 : 2'b10;  // {ifu,lsu}: IFU, LSU, IFU
      #1;
      n_checks++; if ({ifu_req_ready, lsu_req_ready} !== exp_grant) begin n_fail++; $display("FAIL t2_grant_r%0d: got %b want %b", r, {ifu_req_ready, lsu_req_ready}, exp_grant); end
      tick();
      if (exp_grant[1]) ifu_req_valid = 0; else lsu_req_valid = 0;
      n_checks++; if (mem_bus.mem_addr !== (exp_grant[1] ? 32'h100 : 32'h200)) begin n_fail++; $display("FAIL t2_addr_r%0d: got %h", r, mem_bus.mem_addr); end
      tick(); mem_bus.mem_rsp_valid = 1; mem_bus.mem_rdata = 32'hA0 + r;
      tick(); mem_bus.mem_rsp_valid = 0;
      n_checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== exp_grant) begin n_fail++; $display("FAIL t2_rsp_r%0d: got %b want %b", r, {ifu_rsp_valid, lsu_rsp_valid}, exp_grant); end
      $display("txn rr round %0d: winner=%s", r, exp_grant[1] ? "ifu" : "lsu");
      if (exp_grant[1]) ifu_req_valid = (r < 2); else lsu_req_valid = (r < 2);
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    tick();
    n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL t2_idle_after: got %b want 0", mem_bus.mem_req_valid); end
  endtask

  task automatic test_store_backpressure();
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_memop = 3'b001;
    mem_bus.mem_req_ready = 0;
    #1;
    n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin n_fail++; $display("FAIL t3_ready: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
    tick(); lsu_req_valid = 0;
    for (int i = 1; i <= 6; i++) begin
      n_checks++; if ({mem_bus.mem_req_valid, mem_bus.mem_wen, mem_bus.mem_memop, mem_bus.mem_addr, mem_bus.mem_wdata} !== {1'b1, 1'b1, 3'b001, 32'h8000_1000, 32'hDEAD_BEEF}) begin
        n_fail++; $display("FAIL t3_hold_c%0d: got v=%b w=%b op=%b a=%h d=%h", i, mem_bus.mem_req_valid, mem_bus.mem_wen, mem_bus.mem_memop, mem_bus.mem_addr, mem_bus.mem_wdata);
      end
      if (i == 6) mem_bus.mem_req_ready = 1;
      tick();
    end
    mem_bus.mem_req_ready = 0; mem_bus.mem_rsp_valid = 1; mem_bus.mem_rdata = 32'h1;
    n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL t3_drop: got %b want 0", mem_bus.mem_req_valid); end
    tick(); mem_bus.mem_rsp_valid = 0;
    n_checks++; if ({lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid, lsu_rdata} !== {3'b100, 32'h1}) begin n_fail++; $display("FAIL t3_rsp: got v=%b e=%b iv=%b d=%h", lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid, lsu_rdata); end
    lsu_wen = 0;
    tick();
    $display("txn store: addr=80001000 data=deadbeef");
  endtask

  task automatic test_timeout();
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_memop = 3'b010; mem_bus.mem_req_ready = 1;
    tick(); lsu_req_valid = 0;
    tick(); mem_bus.mem_req_ready = 0;
    for (int i = 2; i <= 5; i++) begin
      n_checks++; if (lsu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t4_early_c%0d: got %b want 0", i, lsu_rsp_valid); end
      tick();
    end
    n_checks++; if ({lsu_rsp_valid, lsu_rsp_err, lsu_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL t4_timeout: got v=%b e=%b d=%h want 1 1 0", lsu_rsp_valid, lsu_rsp_err, lsu_rdata); end
    tick(); mem_bus.mem_rsp_valid = 1; mem_bus.mem_rdata = 32'hBAD0_BAD0;
    tick(); mem_bus.mem_rsp_valid = 0;
    n_checks++; if ({lsu_rsp_valid, ifu_rsp_valid, lsu_rdata} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL t4_late_rsp: got lv=%b iv=%b d=%h", lsu_rsp_valid, ifu_rsp_valid, lsu_rdata); end
    $display("txn timeout: lsu err=1");
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004; mem_bus.mem_req_ready = 1;
    #1;
    n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t4_next_grant: got %b want 1", ifu_req_ready); end
    tick(); ifu_req_valid = 0;
    tick(); mem_bus.mem_req_ready = 0; mem_bus.mem_rsp_valid = 1; mem_bus.mem_rdata = 32'h13;
    tick(); mem_bus.mem_rsp_valid = 0;
    n_checks++; if ({ifu_rsp_valid, ifu_rsp_err, ifu_rdata} !== {2'b10, 32'h13}) begin n_fail++; $display("FAIL t4_next_rsp: got v=%b e=%b d=%h", ifu_rsp_valid, ifu_rsp_err, ifu_rdata); end
    tick();
    $display("txn fetch after timeout: rdata=%h", ifu_rdata);
  endtask

  task automatic test_rsp_on_timeout_cycle();
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_memop = 3'b010; mem_bus.mem_req_ready = 1;
    tick(); lsu_req_valid = 0;
    tick(); mem_bus.mem_req_ready = 0;
    tick(); tick(); tick();
    mem_bus.mem_rsp_valid = 1; mem_bus.mem_rdata = 32'h1234_5678;  // 4th WAIT cycle
    tick(); mem_bus.mem_rsp_valid = 0;
    n_checks++; if ({lsu_rsp_valid, lsu_rsp_err, lsu_rdata} !== {2'b10, 32'h1234_5678}) begin n_fail++; $display("FAIL t5_rsp_wins: got v=%b e=%b d=%h", lsu_rsp_valid, lsu_rsp_err, lsu_rdata); end
    tick();
    $display("txn rsp on timeout cycle: rdata=%h", lsu_rdata);
  endtask

  task automatic test_reset_mid_wait();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008; mem_bus.mem_req_ready = 1;
    tick(); ifu_req_valid = 0;
    tick(); mem_bus.mem_req_ready = 0;
    tick();
    rst = 1;
    #1;
    n_checks++; if ({mem_bus.mem_req_valid, mem_bus.mem_memop, mem_bus.mem_addr} !== 36'h0) begin n_fail++; $display("FAIL t6_mem_zero: got v=%b op=%b a=%h", mem_bus.mem_req_valid, mem_bus.mem_memop, mem_bus.mem_addr); end
    n_checks++; if ({ifu_rdata, lsu_rdata} !== 64'h0) begin n_fail++; $display("FAIL t6_rdata_zero: got %h want 0", {ifu_rdata, lsu_rdata}); end
    tick();
    rst = 0;
    mem_bus.mem_rsp_valid = 1; mem_bus.mem_rdata = 32'hCAFE_F00D;
    tick(); mem_bus.mem_rsp_valid = 0;
    n_checks++; if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rdata} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL t6_ignored_rsp: got iv=%b lv=%b d=%h", ifu_rsp_valid, lsu_rsp_valid, ifu_rdata); end
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin n_fail++; $display("FAIL t6_first_grant: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
    ifu_req_valid = 0; lsu_req_valid = 0;
    tick();
    $display("txn reset mid-wait: abandoned");
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_round_robin();
    test_store_backpressure();
    test_timeout();
    test_rsp_on_timeout_cycle();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IFU) and load/store (LSU).
- Issues one transaction at a time over valid/ready handshakes, using round-robin arbitration between the two requesters.
- Routes each response back to the requester that issued it, and enforces a response timeout.
- Sits between the CPU core (fetch path, mem_addr/memdata/mem_wen/memop path) and the memory model / bus bridge.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles before an error response; valid range 1..65535

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  fetch response pulse
- ifu_rsp_err  out  1  fetch timed out
- ifu_rdata  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted
- lsu_addr  in  ADDR_W  data address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DATA_W  store data
- lsu_memop  in  3  access size/sign code, passed through unchanged
- lsu_rsp_valid  out  1  load/store response pulse
- lsu_rsp_err  out  1  load/store timed out
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DATA_W  registered write data
- mem_memop  out  3  registered memop; 3'b010 (word) for fetches
- mem_rsp_valid  in  1  memory response, one per request; writes are acked too
- mem_rdata  in  DATA_W  response data

Behaviour:
- Reset (async, active-high): state IDLE, owner = IFU, last_grant = LSU (so IFU wins the first tie).
  - All outputs are 0 during reset, including mem_memop and all rdata outputs.
  - Reset asserted mid-transaction abandons the transaction. No response is issued, and a late mem_rsp_valid after reset is ignored.
- FSM states:
  - IDLE: grant chosen combinationally.
    - Only one requester valid: that requester wins.
    - Both valid: the one not granted last wins.
    - The winner's *_req_ready = 1 in the same cycle. Only one ready may be high in any cycle; neither is high outside IDLE.
    - On grant: latch owner, addr, wen, wdata and memop into the mem_* registers; update last_grant; go to REQ.
    - For a fetch: wen = 0, memop = 3'b010, wdata = 0.
  - REQ: mem_req_valid = 1 and the mem_* fields are stable.
    - mem_req_ready = 1 → go to WAIT, clear the timeout counter, drop mem_req_valid next cycle.
    - Otherwise stay in REQ indefinitely; no timeout applies in REQ.
  - WAIT: the counter increments every cycle.
    - mem_rsp_valid = 1: register mem_rdata into the owner's rdata and pulse the owner's rsp_valid for exactly 1 cycle (the cycle after mem_rsp_valid), rsp_err = 0; go to IDLE.
    - Counter reaches TIMEOUT with no response: owner's rsp_valid = 1 and rsp_err = 1 for 1 cycle, rdata = 0; go to IDLE.
    - mem_rsp_valid in the same cycle the counter hits TIMEOUT: the response wins and rsp_err = 0.
- mem_rsp_valid seen outside WAIT is ignored.
- The non-owner's rsp_valid never pulses. Each rdata holds its value until that requester's next response.
- Latency, with memory ready and responding immediately:
  - accept at cycle 0, mem_req_valid at cycle 1, WAIT from cycle 2;
  - mem_rsp_valid at cycle 2 gives rsp_valid at cycle 3;
  - the next grant is possible at cycle 3 (state is IDLE at cycle 3).
- The IDLE grant coincides with the rsp_valid pulse of the previous transaction. This back-to-back case is legal.
- Requesters must hold their request fields stable while valid and not ready. The block does not check this.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, REQ, WAIT};
  - owner encoding OWN_IFU = 0, OWN_LSU = 1;
  - MEMOP_WORD = 3'b010 (plus the other memop codes already used by the control generator).
- One sub-module: rr_arbiter_2.
  - Inputs: two request bits and last_grant.
  - Outputs: one-hot grant.
  - Purely combinational. The last_grant register stays in the parent.

Test Plan:
1. Lone fetch: ifu_req_valid with ifu_addr = 0x80000000; memory ready at once and returns 0x00000413 one cycle later → ifu_req_ready at cycle 0, mem_req_valid at cycle 1 with mem_memop = 3'b010, ifu_rsp_valid at cycle 3 with ifu_rdata = 0x00000413, lsu_rsp_valid stays 0.
2. Simultaneous requests after reset, repeated three times → grants in order IFU, LSU, IFU; each requester gets exactly one rsp_valid per grant.
3. Store: lsu_wen = 1, lsu_addr = 0x80001000, lsu_wdata = 0xDEADBEEF, lsu_memop = 3'b001; mem_req_ready held low for 5 cycles → mem_req_valid held for 6 cycles with stable fields; lsu_rsp_valid follows the ack.
4. Timeout: TIMEOUT = 4, memory never responds → after 4 WAIT cycles lsu_rsp_valid = 1, lsu_rsp_err = 1, lsu_rdata = 0; a later mem_rsp_valid is ignored and the next request is granted normally.
5. Response on the timeout cycle: mem_rsp_valid arrives in the same cycle the counter reaches TIMEOUT → rsp_err = 0 and rdata = mem_rdata.
6. Reset mid-WAIT: assert rst in WAIT, then deliver mem_rsp_valid after release → outputs are 0 immediately, no rsp_valid occurs, and the first request after reset is granted to IFU.
